// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: two-stage ARM64 immediate extender with valid/ready and a saturating illegal-format counter.
// Define IMM_EXT_SHIFT12_EN to make I format honour instr[22] (imm12 << 12).
module imm_ext_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [2:0]            fmt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] imm_ext,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  err_cnt
);
  logic [25:0] instr1;
  logic [2:0] fmt1;
  logic ill1, v1, v2, ld2, in_xfer, unused_bits;
  logic [63:0] iw;
  logic [DATA_WIDTH-1:0] imm_i, imm_d, imm_b, imm_cb, imm_nxt;
  assign ld2 = !v2 || out_ready;
  assign in_ready = !v1 || ld2;
  assign in_xfer = in_valid && in_ready && !flush;
  assign out_valid = v2;
  // instr[31:26] carry opcode bits no format needs; iw bits above DATA_WIDTH are dropped
  assign unused_bits = ^{instr[31:26], iw};
  assign iw = {48'b0, instr1[20:5]} << {instr1[22:21], 4'b0};
`ifdef IMM_EXT_SHIFT12_EN
  assign imm_i = {{(DATA_WIDTH-24){1'b0}}, instr1[22] ? {instr1[21:10], 12'b0} : {12'b0, instr1[21:10]}};
`else
  assign imm_i = {{(DATA_WIDTH-12){1'b0}}, instr1[21:10]};
`endif
  assign imm_d = {{(DATA_WIDTH-9){instr1[20]}}, instr1[20:12]};
  assign imm_b = {{(DATA_WIDTH-28){instr1[25]}}, instr1[25:0], 2'b00};
  assign imm_cb = {{(DATA_WIDTH-21){instr1[23]}}, instr1[23:5], 2'b00};
  assign imm_nxt = fmt1 == 3'd0 ? imm_i :
                   fmt1 == 3'd1 ? imm_d :
                   fmt1 == 3'd2 ? imm_b :
                   fmt1 == 3'd3 ? imm_cb :
                   fmt1 == 3'd4 ? iw[DATA_WIDTH-1:0] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      instr1 <= '0;
      fmt1 <= '0;
      ill1 <= 1'b0;
      imm_ext <= '0;
      illegal <= 1'b0;
      err_cnt <= '0;
    end else begin
      v1 <= !flush && (in_ready ? in_valid : v1);
      v2 <= !flush && (ld2 ? v1 : v2);
      if (in_xfer) begin
        instr1 <= instr[25:0];
        fmt1 <= fmt;
        ill1 <= fmt >= 3'd5;
      end
      if (ld2 && v1 && !flush) begin
        imm_ext <= imm_nxt;
        illegal <= ill1;
      end
      if (in_xfer && fmt >= 3'd5 && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: randomized scoreboard bench for imm_ext_pipe at DATA_WIDTH 64 and 32.
module tb_imm_ext_pipe;
  typedef struct {
    logic [63:0] imm;
    logic ill;
  } exp_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] instr = '0;
  logic [2:0] fmt = '0;
  logic in_ready, out_valid, illegal, in_ready32, out_valid32, ill32;
  logic [63:0] imm_ext;
  logic [31:0] imm32;
  logic [7:0] err_cnt, err32;
  exp_t q[$];
  int checks = 0, passes = 0, cnt = 0;
  logic rand_or = 0, held = 0, h_ill;
  logic [63:0] h_imm;

  imm_ext_pipe #(.DATA_WIDTH(64), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .fmt(fmt), .out_valid(out_valid), .out_ready(out_ready),
    .imm_ext(imm_ext), .illegal(illegal), .err_cnt(err_cnt));

  imm_ext_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .fmt(fmt), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_ext(imm32), .illegal(ill32), .err_cnt(err32));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: field value as a plain integer, then wrapped to 64 bits.
  function automatic logic [63:0] ref_imm(input logic [2:0] f, input logic [31:0] i);
    longint v;
    v = 0;
    case (f)
      3'd0: begin
        v = longint'(i[21:10]);
`ifdef IMM_EXT_SHIFT12_EN
        if (i[22]) v = v * 4096;
`endif
      end
      3'd1: begin
        v = longint'(i[20:12]);
        if (i[20]) v = v - 512;
      end
      3'd2: begin
        v = longint'(i[25:0]) * 4;
        if (i[25]) v = v - (longint'(1) << 28);
      end
      3'd3: begin
        v = longint'(i[23:5]) * 4;
        if (i[23]) v = v - (longint'(1) << 21);
      end
      3'd4: v = longint'(i[20:5]) << (16 * int'(i[22:21]));
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  // Input side: record accepted beats and the expected counter.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      cnt = 0;
    end else begin
      chk("err_cnt", 64'(err_cnt), 64'(cnt));
      chk("err_cnt32", 64'(err32), 64'(cnt));
      if (flush) q.delete();
      else if (in_valid && in_ready) begin
        q.push_back('{ref_imm(fmt, instr), fmt >= 3'd5});
        if (fmt >= 3'd5 && cnt < 255) cnt++;
      end
    end
  end

  // Output side: compare each transferred beat and stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (reset || flush) held = 0;
    else begin
      if (held) begin
        chk("stall_imm", imm_ext, h_imm);
        chk("stall_ill", 64'(illegal), 64'(h_ill));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
        else begin
          e = q.pop_front();
          chk("imm64", imm_ext, e.imm);
          chk("ill64", 64'(illegal), 64'(e.ill));
          chk("valid32", 64'(out_valid32), 64'd1);
          chk("imm32", 64'(imm32), 64'(e.imm[31:0]));
          chk("ill32", 64'(ill32), 64'(e.ill));
        end
      end
      held = out_valid && !out_ready;
      h_imm = imm_ext;
      h_ill = illegal;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_or) out_ready = $urandom_range(0, 3) != 0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] f, input logic [31:0] i);
    int n = 0;
    in_valid = 1;
    fmt = f;
    instr = i;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  initial begin
    idle(3);
    reset = 0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", imm_ext, 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1;
    beat(3'd1, 32'h1FF << 12);
    beat(3'd1, 32'h0FF << 12);
    beat(3'd2, 32'h03FF_FFFF);
    beat(3'd3, 32'h1 << 5);
    beat(3'd4, (32'h2 << 21) | (32'hBEEF << 5));
    beat(3'd4, (32'h3 << 21) | (32'hFFFF << 5));
    beat(3'd0, (32'h1 << 22) | (32'hABC << 10));
    beat(3'd6, 32'hDEAD_BEEF);
    idle(4);
    chk("directed_drain", 64'(q.size()), 64'd0);
    rand_or = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      beat(3'($urandom_range(0, 7)), $urandom);
    end
    rand_or = 0;
    out_ready = 1;
    idle(6);
    chk("rand_drain", 64'(q.size()), 64'd0);
    out_ready = 0;
    beat(3'd1, 32'h1 << 12);
    beat(3'd1, 32'h2 << 12);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_in_ready32", 64'(in_ready32), 64'd0);
    fork
      for (int k = 3; k <= 5; k++) beat(3'd1, 32'(k) << 12);
      begin
        idle(2);
        out_ready = 1;
      end
    join
    idle(5);
    chk("bp_drain", 64'(q.size()), 64'd0);
    out_ready = 0;
    beat(3'd2, 32'h0000_1234);
    beat(3'd3, 32'h00FF_FFE0);
    flush = 1;
    idle(1);
    flush = 0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1;
    idle(5);
    chk("flush_stays_empty", 64'(out_valid), 64'd0);
    flush = 1;
    in_valid = 1;
    fmt = 3'd7;
    instr = $urandom;
    idle(1);
    flush = 0;
    in_valid = 0;
    idle(1);
    chk("flush_ill_cnt", 64'(err_cnt), 64'(cnt));
    chk("flush_ill_empty", 64'(out_valid), 64'd0);
    out_ready = 0;
    beat(3'd4, 32'h0012_3450);
    beat(3'd1, 32'h0010_0000);
    reset = 1;
    idle(1);
    reset = 0;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_imm", imm_ext, 64'd0);
    chk("rst2_illegal", 64'(illegal), 64'd0);
    chk("rst2_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    chk("rst2_in_ready32", 64'(in_ready32), 64'd1);
    out_ready = 1;
    idle(4);
    chk("rst2_no_output", 64'(out_valid), 64'd0);
    for (int k = 0; k < 300; k++) beat(3'd7, $urandom);
    idle(5);
    chk("sat_err_cnt", 64'(err_cnt), 64'd255);
    chk("sat_err_cnt32", 64'(err32), 64'd255);
    chk("sat_drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
